// File: rtl/tdc_seq_pkg.sv
// tdc_seq_pkg: shared types and constants for the TDC readout sequencer.
package tdc_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitMeas,
    StDrain,
    StRd,
    StCapture,
    StNextGroup,
    StDone,
    StFlush
  } tdc_seq_state_e;

  // Channel headers the setter accepts in word[31:28]
  localparam logic [3:0] HDR_CH_LO = 4'h8;
  localparam logic [3:0] HDR_CH_HI = 4'h9;

  localparam int unsigned GroupCntW   = 3;
  localparam int unsigned WordCntW    = 8;
  localparam int unsigned DiscardCntW = 8;
  localparam int unsigned RdCntW      = 4;

  function automatic logic hdr_valid(input logic [31:0] word);
    return (word[31:28] == HDR_CH_LO) || (word[31:28] == HDR_CH_HI);
  endfunction

endpackage

// File: rtl/tdc_seq_timeout_cnt.sv
// tdc_seq_timeout_cnt: clearable up-counter that holds at its terminal value and flags it.
// Used both for the measurement-wait timeout and for read-strobe width timing.
module tdc_seq_timeout_cnt #(
  parameter int unsigned Width = 10
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr_in,
  input  logic             en_in,
  input  logic [Width-1:0] term_in,
  output logic             tc_out
);

  logic [Width-1:0] cnt_q, cnt_d;

  assign tc_out = (cnt_q == term_in);

  // Next count: clear wins, otherwise count up until the terminal value
  always_comb begin
    cnt_d = cnt_q;
    if (clr_in) begin
      cnt_d = '0;
    end else if (en_in && !tc_out) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tdc_readout_sequencer.sv
// tdc_readout_sequencer: drains one measurement frame from the TDC result FIFO into the data
// setter, one setFlag per valid word and one saveFlag per group.
// Define TDC_SEQ_OVERFLOW_FLUSH_EN to discard words beyond MAX_WORDS instead of leaving them
// in the FIFO for the next group.
module tdc_readout_sequencer
  import tdc_seq_pkg::*;
#(
  parameter int unsigned GROUP_NUM      = 3,
  parameter int unsigned MAX_WORDS      = 8,
  parameter int unsigned RD_WIDTH       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start_in,
  input  logic                   abort_in,
  input  logic                   measDone_in,
  input  logic                   tdcEmpty_in,
  input  logic [31:0]            tdcData_in,
  output logic                   tdcRd_out,
  output logic [31:0]            tdcTimeData_out,
  output logic                   setFlag_out,
  output logic                   saveFlag_out,
  output logic                   busy_out,
  output logic                   done_out,
  output logic                   timeout_out,
  output logic [GroupCntW-1:0]   groupCnt_out,
  output logic [DiscardCntW-1:0] discardCnt_out
);

  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0]        TmoTerm   = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [RdCntW-1:0]      RdTerm    = RdCntW'(RD_WIDTH - 1);
  localparam logic [GroupCntW-1:0]   GroupLast = GroupCntW'(GROUP_NUM - 1);
  localparam logic [WordCntW-1:0]    MaxWords  = WordCntW'(MAX_WORDS);

  tdc_seq_state_e state_q, state_d;

  logic                   rd_q;
  logic                   flush_q;  // previous cycle was a flush read
  logic [31:0]            data_q;
  logic                   timeout_q;
  logic [GroupCntW-1:0]   group_q;
  logic [WordCntW-1:0]    word_q;
  logic [DiscardCntW-1:0] discard_q;
  logic                   tmo_tc;
  logic                   rd_tc;

  tdc_seq_timeout_cnt #(
    .Width (TmoW)
  ) u_tmo_cnt (
    .clk     (clk),
    .resetn  (resetn),
    .clr_in  (state_q != StWaitMeas),
    .en_in   (1'b1),
    .term_in (TmoTerm),
    .tc_out  (tmo_tc)
  );

  tdc_seq_timeout_cnt #(
    .Width (RdCntW)
  ) u_rd_cnt (
    .clk     (clk),
    .resetn  (resetn),
    .clr_in  (!((state_q == StRd) || (state_q == StFlush))),
    .en_in   (1'b1),
    .term_in (RdTerm),
    .tc_out  (rd_tc)
  );

  // Next-state decode; abort overrides every transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (start_in) state_d = StWaitMeas;
      StWaitMeas: begin
        if (measDone_in) begin
          state_d = StDrain;
        end else if (tmo_tc) begin
          state_d = StNextGroup;
        end
      end
      StDrain: begin
        if (!tdcEmpty_in && (word_q < MaxWords)) begin
          state_d = StRd;
        end
`ifdef TDC_SEQ_OVERFLOW_FLUSH_EN
        else if (!tdcEmpty_in) begin
          state_d = StFlush;
        end
`endif
        else begin
          state_d = StNextGroup;
        end
      end
      StRd:        if (rd_tc) state_d = StCapture;
      StFlush:     if (rd_tc) state_d = StCapture;
      StCapture:   state_d = StDrain;
      StNextGroup: state_d = (group_q == GroupLast) ? StDone : StWaitMeas;
      StDone:      state_d = StIdle;
      default:     state_d = StIdle;
    endcase
    if (abort_in) state_d = StIdle;
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: read strobe, captured word, group/word/discard counters and timeout flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_q      <= 1'b0;
      flush_q   <= 1'b0;
      data_q    <= '0;
      timeout_q <= 1'b0;
      group_q   <= '0;
      word_q    <= '0;
      discard_q <= '0;
    end else begin
      rd_q    <= (state_d == StRd) || (state_d == StFlush);
      flush_q <= (state_q == StFlush);
      if (!abort_in) begin
        unique case (state_q)
          StIdle: begin
            if (start_in) begin
              group_q   <= '0;
              timeout_q <= 1'b0;
              discard_q <= '0;
            end
          end
          StWaitMeas: begin
            if (measDone_in) begin
              word_q <= '0;
            end else if (tmo_tc) begin
              timeout_q <= 1'b1;
            end
          end
          StRd: if (rd_tc) data_q <= tdcData_in;
          StCapture: begin
            if (flush_q || !hdr_valid(data_q)) begin
              if (discard_q != '1) discard_q <= discard_q + DiscardCntW'(1);
            end else begin
              word_q <= word_q + WordCntW'(1);
            end
          end
          StNextGroup: if (group_q != GroupLast) group_q <= group_q + GroupCntW'(1);
          default: ;
        endcase
      end
    end
  end

  assign tdcRd_out       = rd_q;
  assign tdcTimeData_out = data_q;
  assign setFlag_out     = (state_q == StCapture) && !flush_q && hdr_valid(data_q);
  assign saveFlag_out    = (state_q == StNextGroup);
  assign done_out        = (state_q == StDone);
  assign busy_out        = (state_q != StIdle);
  assign timeout_out     = timeout_q;
  assign groupCnt_out    = group_q;
  assign discardCnt_out  = discard_q;

endmodule
